// File: rtl/prf_read_arbiter_if.sv
// Request/response and PRF read-port bundle between the issue queues, the read arbiter and the PRF.
// The arbiter connects through the slave modport; the queue/PRF side uses master.
interface prf_read_arbiter_if #(
  parameter int unsigned FU_COUNT     = 4,
  parameter int unsigned MAX_OPERANDS = 3,
  parameter int unsigned PRN_BITS     = 6,
  parameter int unsigned READ_PORTS   = 6
);
  logic [FU_COUNT-1:0]                                   req_valid;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                 req_op_en;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]   req_prn;
  logic [FU_COUNT-1:0]                                   req_grant;
  logic [FU_COUNT-1:0]                                   rsp_valid;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][63:0]           rsp_data;
  logic [READ_PORTS-1:0]                                 prf_read_enable;
  logic [READ_PORTS-1:0][PRN_BITS-1:0]                   prf_read_prn;
  logic [READ_PORTS-1:0][63:0]                           prf_read_data;

  modport master (
    output req_valid, req_op_en, req_prn, prf_read_data,
    input  req_grant, rsp_valid, rsp_data, prf_read_enable, prf_read_prn
  );

  modport slave (
    input  req_valid, req_op_en, req_prn, prf_read_data,
    output req_grant, rsp_valid, rsp_data, prf_read_enable, prf_read_prn
  );
endinterface

// File: rtl/prf_read_arbiter.sv
// Round-robin, whole-instruction arbiter sharing the PRF read ports among issue queues, with a
// one-cycle registered port map that steers returned read data back to the granted queues.
module prf_read_arbiter #(
  parameter int unsigned FU_COUNT     = 4,
  parameter int unsigned MAX_OPERANDS = 3,
  parameter int unsigned PRN_BITS     = 6,
  parameter int unsigned READ_PORTS   = 6
) (
  input logic               clk,
  input logic               rst,
  prf_read_arbiter_if.slave bus
);

  localparam int unsigned FuW   = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
  localparam int unsigned FuWp  = FuW + 1;
  localparam int unsigned PortW = (READ_PORTS > 1) ? $clog2(READ_PORTS) : 1;
  localparam int unsigned CntW  = $clog2(READ_PORTS + 1) + 1;

  if (READ_PORTS < MAX_OPERANDS) begin : g_port_check
    $error("prf_read_arbiter: READ_PORTS must be >= MAX_OPERANDS");
  end

  logic [FuW-1:0]                                  rr_q, rr_d;
  logic [FU_COUNT-1:0]                             grant;
  logic [FU_COUNT-1:0]                             rsp_valid_q;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]           lane_en_q, lane_en_d;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PortW-1:0] port_map_q, port_map_d;
  logic [READ_PORTS-1:0]                           port_en;
  logic [READ_PORTS-1:0][PRN_BITS-1:0]             port_prn;

  // Walk queues from rr_q; stop at the first valid requester that does not fit so that
  // large instructions are never starved by smaller ones behind them.
  always_comb begin : arbitrate
    logic [FuWp-1:0] qi_wide;
    logic [FuW-1:0]  qi;
    logic [CntW-1:0] used;
    logic [CntW-1:0] cost;
    logic            stop;
    grant      = '0;
    port_en    = '0;
    port_prn   = '0;
    lane_en_d  = '0;
    port_map_d = '0;
    rr_d       = rr_q;
    used       = '0;
    cost       = '0;
    stop       = 1'b0;
    qi_wide    = '0;
    qi         = '0;
    for (int unsigned v = 0; v < FU_COUNT; v++) begin
      qi_wide = {1'b0, rr_q} + FuWp'(v);
      if (qi_wide >= FuWp'(FU_COUNT)) begin
        qi_wide = qi_wide - FuWp'(FU_COUNT);
      end
      qi   = qi_wide[FuW-1:0];
      cost = '0;
      for (int unsigned k = 0; k < MAX_OPERANDS; k++) begin
        cost = cost + CntW'(bus.req_op_en[qi][k]);
      end
      if (bus.req_valid[qi] && !stop) begin
        if (cost <= CntW'(READ_PORTS) - used) begin
          grant[qi] = 1'b1;
          for (int unsigned k = 0; k < MAX_OPERANDS; k++) begin
            if (bus.req_op_en[qi][k]) begin
              port_en[PortW'(used)]  = 1'b1;
              port_prn[PortW'(used)] = bus.req_prn[qi][k];
              lane_en_d[qi][k]       = 1'b1;
              port_map_d[qi][k]      = PortW'(used);
              used                   = used + CntW'(1);
            end
          end
          rr_d = (qi == FuW'(FU_COUNT - 1)) ? '0 : qi + FuW'(1);
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      rsp_valid_q <= '0;
      lane_en_q   <= '0;
      port_map_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      rsp_valid_q <= grant;
      lane_en_q   <= lane_en_d;
      port_map_q  <= port_map_d;
    end
  end

  assign bus.req_grant       = rst ? '0 : grant;
  assign bus.prf_read_enable = rst ? '0 : port_en;
  assign bus.prf_read_prn    = rst ? '0 : port_prn;
  assign bus.rsp_valid       = rsp_valid_q;

  always_comb begin
    bus.rsp_data = '0;
    for (int unsigned i = 0; i < FU_COUNT; i++) begin
      for (int unsigned k = 0; k < MAX_OPERANDS; k++) begin
        if (rsp_valid_q[i] && lane_en_q[i][k]) begin
          bus.rsp_data[i][k] = bus.prf_read_data[port_map_q[i][k]];
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_read_arbiter.sv
// Directed bench for prf_read_arbiter: a request-level reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_prf_read_arbiter;
  localparam int FU = 4;
  localparam int MO = 3;
  localparam int PB = 6;
  localparam int RP = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  prf_read_arbiter_if #(.FU_COUNT(FU), .MAX_OPERANDS(MO), .PRN_BITS(PB), .READ_PORTS(RP)) bus ();

  prf_read_arbiter #(.FU_COUNT(FU), .MAX_OPERANDS(MO), .PRN_BITS(PB), .READ_PORTS(RP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [63:0] mem_val(input logic [5:0] prn);
    return {16'hC0DE, 10'h0, prn, 16'hBEEF, 10'h0, prn};
  endfunction

  // PRF stand-in: registered read, junk on idle ports.
  always @(posedge clk) begin
    for (int p = 0; p < RP; p++) begin
      bus.prf_read_data[p] <= bus.prf_read_enable[p] ? mem_val(bus.prf_read_prn[p])
                                                     : 64'hDEAD_BEEF_DEAD_BEEF;
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cycle, act, exp);
    end
  endtask

  function automatic void model_arb(input logic [3:0] valid, input logic [3:0][2:0] en,
                                    input logic [3:0][2:0][5:0] prn, input int rr,
                                    output logic [3:0] g, output logic [RP-1:0] pe,
                                    output logic [RP-1:0][5:0] pp, output int rr_n);
    logic [5:0] addrs[$];
    int free;
    g = '0; pe = '0; pp = '0; rr_n = rr; free = RP;
    for (int v = 0; v < FU; v++) begin
      int i;
      i = (rr + v) % FU;
      if (!valid[i]) continue;
      if ($countones(en[i]) > free) break;
      g[i] = 1'b1;
      free -= $countones(en[i]);
      for (int k = 0; k < MO; k++) if (en[i][k]) addrs.push_back(prn[i][k]);
      rr_n = (i + 1) % FU;
    end
    foreach (addrs[p]) begin
      pe[p] = 1'b1;
      pp[p] = addrs[p];
    end
  endfunction

  // Reference model state.
  int                   m_rr = 0;
  logic [3:0]           m_rv = '0;
  logic [3:0][2:0][63:0] m_rd = '0;

  always @(negedge clk) begin
    if (cycle >= 1) begin
      logic [3:0]         g;
      logic [RP-1:0]      pe;
      logic [RP-1:0][5:0] pp;
      int                 rr_n;
      if (rst) begin
        g = '0; pe = '0; pp = '0; rr_n = 0;
      end else begin
        model_arb(bus.req_valid, bus.req_op_en, bus.req_prn, m_rr, g, pe, pp, rr_n);
      end
      check("req_grant", 256'(bus.req_grant), 256'(g));
      check("prf_read_enable", 256'(bus.prf_read_enable), 256'(pe));
      check("prf_read_prn", 256'(bus.prf_read_prn), 256'(pp));
      check("rsp_valid", 256'(bus.rsp_valid), 256'(m_rv));
      for (int i = 0; i < FU; i++) check($sformatf("rsp_data[%0d]", i),
                                         256'(bus.rsp_data[i]), 256'(m_rd[i]));
      m_rv = g;
      for (int i = 0; i < FU; i++)
        for (int k = 0; k < MO; k++)
          m_rd[i][k] = (g[i] && bus.req_op_en[i][k]) ? mem_val(bus.req_prn[i][k]) : 64'h0;
      m_rr = rr_n;
    end
  end

  function automatic logic [2:0][5:0] ops(input logic [5:0] p0, input logic [5:0] p1,
                                          input logic [5:0] p2);
    return {p2, p1, p0};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0][2:0] en,
                       input logic [3:0][2:0][5:0] prn);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_op_en = en;
    bus.req_prn   = prn;
  endtask

  task automatic mid;
    @(negedge clk);
    #1;
  endtask

  logic [3:0][2:0][5:0] prns_a;

  initial begin
    prns_a = {ops(10, 11, 12), ops(7, 8, 9), ops(4, 5, 6), ops(1, 2, 3)};
    bus.req_valid = 4'b1111;
    bus.req_op_en = {3'b111, 3'b111, 3'b111, 3'b111};
    bus.req_prn   = prns_a;

    // Reset held two cycles with everyone requesting.
    mid();
    check("reset grant", 256'(bus.req_grant), 256'(4'b0000));
    check("reset enable", 256'(bus.prf_read_enable), 256'(6'b0));
    check("reset rsp_valid", 256'(bus.rsp_valid), 256'(4'b0000));
    @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin with all queues at cost 3.
    mid();
    check("rr first grant", 256'(bus.req_grant), 256'(4'b0011));
    mid();
    check("rr second grant", 256'(bus.req_grant), 256'(4'b1100));
    check("rr second rsp_valid", 256'(bus.rsp_valid), 256'(4'b0011));
    check("rr rsp q0 lane0", 256'(bus.rsp_data[0][0]), 256'(mem_val(6'd1)));
    mid();
    check("rr third grant", 256'(bus.req_grant), 256'(4'b0011));
    mid();
    check("rr fourth grant", 256'(bus.req_grant), 256'(4'b1100));

    // Fit: q0 and q1 fill all six ports, q2 left waiting.
    drive(4'b0111, {3'b000, 3'b001, 3'b111, 3'b111},
          {ops(0, 0, 0), ops(11, 0, 0), ops(8, 9, 10), ops(5, 6, 7)});
    mid();
    check("fit grant", 256'(bus.req_grant), 256'(4'b0011));
    check("fit enable", 256'(bus.prf_read_enable), 256'(6'b111111));
    check("fit port0 prn", 256'(bus.prf_read_prn[0]), 256'(6'd5));
    check("fit port5 prn", 256'(bus.prf_read_prn[5]), 256'(6'd10));
    drive(4'b0000, '0, '0);
    mid();
    check("fit rsp_valid", 256'(bus.rsp_valid), 256'(4'b0011));
    check("fit rsp q1 lane2", 256'(bus.rsp_data[1][2]), 256'(mem_val(6'd10)));

    // No-skip from rr_ptr=2: q2(3)+q3(2) granted, q0(3) stops the walk, q1(1) must wait.
    drive(4'b1111, {3'b011, 3'b111, 3'b001, 3'b111},
          {ops(27, 28, 0), ops(24, 25, 26), ops(23, 0, 0), ops(20, 21, 22)});
    mid();
    check("noskip grant", 256'(bus.req_grant), 256'(4'b1100));
    mid();
    check("noskip follow grant", 256'(bus.req_grant), 256'(4'b0011));

    // Sparse operands on q3.
    drive(4'b1000, {3'b101, 3'b000, 3'b000, 3'b000},
          {ops(12, 13, 14), ops(0, 0, 0), ops(0, 0, 0), ops(0, 0, 0)});
    mid();
    check("sparse grant", 256'(bus.req_grant), 256'(4'b1000));
    check("sparse enable", 256'(bus.prf_read_enable), 256'(6'b000011));
    check("sparse port1 prn", 256'(bus.prf_read_prn[1]), 256'(6'd14));
    drive(4'b0000, '0, '0);
    mid();
    check("sparse rsp lane0", 256'(bus.rsp_data[3][0]), 256'(mem_val(6'd12)));
    check("sparse rsp lane1", 256'(bus.rsp_data[3][1]), 256'(64'h0));
    check("sparse rsp lane2", 256'(bus.rsp_data[3][2]), 256'(mem_val(6'd14)));

    // Cost-0 grant, then reset landing on a grant cycle.
    drive(4'b0010, '0, '0);
    mid();
    check("cost0 grant", 256'(bus.req_grant), 256'(4'b0010));
    check("cost0 enable", 256'(bus.prf_read_enable), 256'(6'b0));
    drive(4'b0100, {3'b000, 3'b011, 3'b000, 3'b000},
          {ops(0, 0, 0), ops(30, 31, 0), ops(0, 0, 0), ops(0, 0, 0)});
    mid();
    check("cost0 rsp_valid", 256'(bus.rsp_valid), 256'(4'b0010));
    check("cost0 rsp data", 256'(bus.rsp_data[1]), 256'(0));
    check("pre-reset grant", 256'(bus.req_grant), 256'(4'b0100));
    @(posedge clk);
    #1 rst = 1'b1;
    mid();
    check("midreset grant", 256'(bus.req_grant), 256'(4'b0000));
    check("midreset rsp_valid", 256'(bus.rsp_valid), 256'(4'b0100));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_op_en = {3'b111, 3'b111, 3'b111, 3'b111};
    bus.req_prn   = prns_a;
    mid();
    check("postreset rsp_valid", 256'(bus.rsp_valid), 256'(4'b0000));
    check("postreset grant", 256'(bus.req_grant), 256'(4'b0011));
    drive(4'b0000, '0, '0);
    mid();
    mid();
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
